// File: rtl/add_rkey_bank_pkg.sv
// Shared constants and types for the AES AddRoundKey bank.
package add_rkey_bank_pkg;

  localparam int unsigned AesDataW      = 128;
  localparam int unsigned NumKeysAes128 = 11;
  localparam int unsigned NumKeysAes192 = 13;
  localparam int unsigned NumKeysAes256 = 15;

  typedef enum logic {
    DirEnc = 1'b0,
    DirDec = 1'b1
  } dir_e;

endpackage

// File: rtl/add_rkey_bank_if.sv
// State-in / state-out valid-ready handshake of the AddRoundKey bank.
interface add_rkey_bank_if #(
  parameter int unsigned DATA_W = add_rkey_bank_pkg::AesDataW
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dout;
  logic              out_last;
  logic              out_err;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, out_last, out_err
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, out_last, out_err
  );
endinterface

// File: rtl/add_rkey_bank_seq.sv
// Round counter: start value, direction latch, advance with wrap, and final-entry index.
module add_rkey_bank_seq
  import add_rkey_bank_pkg::*;
#(
  parameter int unsigned NUM_KEYS = NumKeysAes256,
  parameter int unsigned IDX_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             dec_i,
  input  logic             adv_i,
  output logic [IDX_W-1:0] round_idx_o,
  output logic [IDX_W-1:0] cur_idx_o,
  output logic [IDX_W-1:0] final_idx_o
);

  localparam logic [IDX_W-1:0] TopIdx = IDX_W'(NUM_KEYS - 1);

  dir_e             dir_q, dir_d, cur_dir;
  logic [IDX_W-1:0] cnt_q, cnt_d, start_idx, final_idx;

  // A start in this cycle takes effect immediately for the beat being accepted.
  always_comb begin
    cur_dir   = start_i ? dir_e'(dec_i) : dir_q;
    start_idx = (cur_dir == DirDec) ? TopIdx : '0;
    final_idx = (cur_dir == DirDec) ? '0 : TopIdx;
    dir_d     = cur_dir;
    cnt_d     = cnt_q;
    if (start_i) begin
      cnt_d = start_idx;
    end else if (adv_i) begin
      if (cnt_q == final_idx) begin
        cnt_d = start_idx;
      end else if (dir_q == DirDec) begin
        cnt_d = cnt_q - IDX_W'(1);
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q <= DirEnc;
      cnt_q <= '0;
    end else begin
      dir_q <= dir_d;
      cnt_q <= cnt_d;
    end
  end

  assign round_idx_o = cnt_q;
  assign cur_idx_o   = start_i ? start_idx : cnt_q;
  assign final_idx_o = final_idx;

endmodule

// File: rtl/add_rkey_bank.sv
// Round-key bank with a single registered XOR stage (AES AddRoundKey) and round sequencing.
module add_rkey_bank
  import add_rkey_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = AesDataW,
  parameter int unsigned NUM_KEYS = NumKeysAes256,
  parameter int unsigned IDX_W    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               kwr_en_i,
  input  logic [IDX_W-1:0]   kwr_idx_i,
  input  logic [DATA_W-1:0]  kwr_key_i,
  input  logic               start_i,
  input  logic               dec_i,
  input  logic               auto_idx_i,
  input  logic [IDX_W-1:0]   sel_idx_i,
  add_rkey_bank_if.slave     bus_io,
  output logic [IDX_W-1:0]   round_idx_o
);

  logic [DATA_W-1:0]   key_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] loaded_q;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  logic              in_ready, accept;
  logic [IDX_W-1:0]  cur_idx, final_idx, idx;
  logic [DATA_W-1:0] key_sel;
  logic              key_ok;

  assign in_ready = !out_valid_q || bus_io.out_ready;
  assign accept   = bus_io.in_valid && in_ready;

  add_rkey_bank_seq #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_seq (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .dec_i       (dec_i),
    .adv_i       (accept && auto_idx_i),
    .round_idx_o (round_idx_o),
    .cur_idx_o   (cur_idx),
    .final_idx_o (final_idx)
  );

  assign idx = auto_idx_i ? cur_idx : sel_idx_i;

  // Out-of-range indices never match an entry, so they read as an unloaded zero key.
  always_comb begin
    key_sel = '0;
    key_ok  = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (idx == IDX_W'(i) && loaded_q[i]) begin
        key_sel = key_q[i];
        key_ok  = 1'b1;
      end
    end
  end

  // Reads above use the registered bank, so a same-cycle write is seen only by later beats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loaded_q <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        key_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (kwr_en_i && kwr_idx_i == IDX_W'(i)) begin
          key_q[i]    <= kwr_key_i;
          loaded_q[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    last_d      = last_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      dout_d      = bus_io.din ^ key_sel;
      last_d      = (idx == final_idx);
      err_d       = !key_ok;
    end else if (bus_io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.dout      = dout_q;
  assign bus_io.out_last  = last_q;
  assign bus_io.out_err   = err_q;

endmodule

// File: tb/tb_add_rkey_bank.sv
// Bench for add_rkey_bank: directed scenarios plus random traffic against a beat-queue model.
module tb_add_rkey_bank;

  localparam int unsigned DW = 128;
  localparam int unsigned N  = 11;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          kwr_en;
  logic [IW-1:0] kwr_idx;
  logic [DW-1:0] kwr_key;
  logic          start;
  logic          dec;
  logic          auto_idx;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] round_idx;

  add_rkey_bank_if #(.DATA_W(DW)) bus ();

  add_rkey_bank #(
    .DATA_W   (DW),
    .NUM_KEYS (N),
    .IDX_W    (IW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .kwr_en_i    (kwr_en),
    .kwr_idx_i   (kwr_idx),
    .kwr_key_i   (kwr_key),
    .start_i     (start),
    .dec_i       (dec),
    .auto_idx_i  (auto_idx),
    .sel_idx_i   (sel_idx),
    .bus_io      (bus),
    .round_idx_o (round_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dout;
    bit            last;
    bit            err;
  } beat_t;

  // Reference state: key table, loaded flags, round position/direction, pending beats.
  logic [DW-1:0] m_key    [16];
  bit            m_loaded [16];
  int            m_ctr;
  bit            m_dir;
  beat_t         q [$];

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_key[i]    = '0;
      m_loaded[i] = 1'b0;
    end
    m_ctr = 0;
    m_dir = 1'b0;
    q.delete();
  endtask

  task automatic idle();
    kwr_en        = 1'b0;
    kwr_idx       = '0;
    kwr_key       = '0;
    start         = 1'b0;
    dec           = 1'b0;
    auto_idx      = 1'b0;
    sel_idx       = '0;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    beat_t b;
    int    idx;
    bit    rdy;
    bit    acc;
    #1;
    rdy = (q.size() == 0) || bus.out_ready;
    check_eq("in_ready", DW'(bus.in_ready), DW'(rdy));
    check_eq("out_valid", DW'(bus.out_valid), DW'(q.size() != 0));
    if (q.size() != 0) begin
      check_eq("dout", bus.dout, q[0].dout);
      check_eq("out_last", DW'(bus.out_last), DW'(q[0].last));
      check_eq("out_err", DW'(bus.out_err), DW'(q[0].err));
    end
    acc = bus.in_valid && rdy;
    if (start) begin
      m_dir = dec;
      m_ctr = dec ? N - 1 : 0;
    end
    if (acc) begin
      idx    = auto_idx ? m_ctr : int'(sel_idx);
      b.err  = !(idx < N && m_loaded[idx]);
      b.dout = bus.din ^ (b.err ? '0 : m_key[idx]);
      b.last = (idx == (m_dir ? 0 : N - 1));
      if (auto_idx && !start) begin
        if (b.last) m_ctr = m_dir ? N - 1 : 0;
        else        m_ctr = m_dir ? m_ctr - 1 : m_ctr + 1;
      end
    end
    if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
    if (acc) q.push_back(b);
    if (kwr_en && kwr_idx < N) begin
      m_key[kwr_idx]    = kwr_key;
      m_loaded[kwr_idx] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("round_idx", DW'(round_idx), DW'(m_ctr));
    @(negedge clk);
  endtask

  task automatic write_key(input int idx, input logic [DW-1:0] key);
    idle();
    kwr_en  = 1'b1;
    kwr_idx = IW'(idx);
    kwr_key = key;
    step();
  endtask

  logic [DW-1:0] held;
  int            lasts;

  initial begin
    model_reset();
    idle();
    rst_n = 1'b0;
    #12;
    check_eq("rst_out_valid", DW'(bus.out_valid), '0);
    check_eq("rst_in_ready", DW'(bus.in_ready), DW'(1));
    check_eq("rst_dout", bus.dout, '0);
    check_eq("rst_round_idx", DW'(round_idx), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 round-0 AddRoundKey.
    write_key(0, 128'h000102030405060708090a0b0c0d0e0f);
    idle();
    bus.in_valid = 1'b1;
    bus.din      = 128'h00112233445566778899aabbccddeeff;
    step();
    idle();
    check_eq("fips_dout", bus.dout, 128'h00102030405060708090a0b0c0d0e0f0);
    check_eq("fips_err", DW'(bus.out_err), '0);
    step();

    // Load all keys; writes beyond the bank must be ignored.
    for (int i = 0; i < 16; i++) write_key(i, rand_word());

    // Encrypt then decrypt sweeps over the full key schedule.
    for (int d = 0; d < 2; d++) begin
      idle();
      start = 1'b1;
      dec   = d[0];
      step();
      lasts = 0;
      for (int k = 0; k < N; k++) begin
        idle();
        auto_idx     = 1'b1;
        bus.in_valid = 1'b1;
        bus.din      = rand_word();
        step();
        lasts += int'(bus.out_last);
      end
      check_eq(d ? "dec_lasts" : "enc_lasts", DW'(lasts), DW'(1));
      check_eq(d ? "dec_last_beat" : "enc_last_beat", DW'(bus.out_last), DW'(1));
      check_eq(d ? "dec_wrap" : "enc_wrap", DW'(round_idx), d ? DW'(N - 1) : '0);
      idle();
      step();
    end

    // Backpressure: a pending beat must hold and the counter must not move.
    idle();
    auto_idx      = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.din       = rand_word();
    step();
    held = bus.dout;
    for (int k = 0; k < 3; k++) begin
      bus.din = rand_word();
      step();
    end
    check_eq("hold_dout", bus.dout, held);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.din = rand_word();
      step();
    end
    idle();
    step();

    // Out-of-range selections read as zero key with error.
    for (int s = 11; s < 16; s += 4) begin
      idle();
      sel_idx      = IW'(s);
      bus.in_valid = 1'b1;
      bus.din      = rand_word();
      held         = bus.din;
      step();
      check_eq("oor_dout", bus.dout, held);
      check_eq("oor_err", DW'(bus.out_err), DW'(1));
    end

    // Reset mid-operation with a pending beat at round 4.
    idle();
    start = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      idle();
      auto_idx     = 1'b1;
      bus.in_valid = 1'b1;
      bus.din      = rand_word();
      step();
    end
    idle();
    bus.out_ready = 1'b0;
    check_eq("pre_rst_idx", DW'(round_idx), DW'(4));
    check_eq("pre_rst_valid", DW'(bus.out_valid), DW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", DW'(bus.out_valid), '0);
    check_eq("arst_idx", DW'(round_idx), '0);
    check_eq("arst_ready", DW'(bus.in_ready), DW'(1));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Loaded flags were cleared by reset.
    idle();
    sel_idx      = IW'(5);
    bus.in_valid = 1'b1;
    bus.din      = rand_word();
    held         = bus.din;
    step();
    check_eq("unloaded_dout", bus.dout, held);
    check_eq("unloaded_err", DW'(bus.out_err), DW'(1));

    // Same-cycle write and accept on one entry uses the old key.
    write_key(3, 128'h0f0e0d0c0b0a09080706050403020100);
    idle();
    kwr_en       = 1'b1;
    kwr_idx      = IW'(3);
    kwr_key      = rand_word();
    sel_idx      = IW'(3);
    bus.in_valid = 1'b1;
    bus.din      = 128'h0;
    step();
    check_eq("rw_old_key", bus.dout, 128'h0f0e0d0c0b0a09080706050403020100);
    idle();
    step();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      kwr_en        = ($urandom_range(3) == 0);
      kwr_idx       = IW'($urandom_range(15));
      kwr_key       = rand_word();
      start         = ($urandom_range(15) == 0);
      dec           = $urandom_range(1);
      auto_idx      = ($urandom_range(3) != 0);
      sel_idx       = IW'($urandom_range(15));
      bus.in_valid  = $urandom_range(1);
      bus.din       = rand_word();
      bus.out_ready = ($urandom_range(3) != 0);
      step();
    end
    idle();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_rkey_bank.md
ADD_RKEY_BANK -- requirements
Module: add_rkey_bank

Interface
REQ-001 Parameter DATA_W, default 128, width of state and round key.
REQ-002 Parameter NUM_KEYS, default 15, number of round-key entries (Nr+1; 11/13/15 for AES-128/192/256).
REQ-003 Parameter IDX_W, default 4, width of key index; SHALL satisfy 2^IDX_W >= NUM_KEYS.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 kwr_en  input  1  write round key this cycle.
REQ-007 kwr_idx  input  IDX_W  key entry written.
REQ-008 kwr_key  input  DATA_W  round-key value.
REQ-009 start  input  1  restart round sequence.
REQ-010 dec  input  1  sequence direction, sampled on start; 1 = descending (decrypt).
REQ-011 auto_idx  input  1  1 = key index from internal round counter; 0 = from sel_idx.
REQ-012 sel_idx  input  IDX_W  explicit key index when auto_idx=0.
REQ-013 in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-014 din  input  DATA_W  state in.
REQ-015 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-016 dout  output  DATA_W  din XOR selected round key.
REQ-017 out_last  output  1  beat used final key of sequence.
REQ-018 out_err  output  1  beat used unloaded or out-of-range key.
REQ-019 round_idx  output  IDX_W  current round-counter value.

Function
REQ-020 Bank SHALL hold NUM_KEYS registered entries plus a per-entry loaded bit; kwr_en with kwr_idx < NUM_KEYS writes entry and sets loaded bit; kwr_idx >= NUM_KEYS ignored.
REQ-021 Accept = in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (single output stage, full throughput).
REQ-022 On accept, dout <= din ^ key[idx], out_valid <= 1 next cycle; latency exactly 1 cycle.
REQ-023 out_valid SHALL clear when out_ready && no accept; dout/out_last/out_err SHALL hold while out_valid && !out_ready.
REQ-024 idx = auto_idx ? round_idx : sel_idx.
REQ-025 idx >= NUM_KEYS or entry not loaded: key treated as zero, out_err=1 for that beat.
REQ-026 Same-cycle write and accept on same index: accept SHALL use pre-write key value.
REQ-027 Round counter: start loads 0 (dec=0) or NUM_KEYS-1 (dec=1) and latches direction; start has priority over any same-cycle accept advance.
REQ-028 Accept with auto_idx=1 and no start: counter advances by +1 (enc) or -1 (dec); on final entry (NUM_KEYS-1 enc, 0 dec) it wraps to its start value and out_last=1 for that beat.
REQ-029 Accept with auto_idx=0 SHALL not alter counter; out_last=1 iff sel_idx equals final entry for latched direction.
REQ-030 Accept same cycle as start SHALL use the newly loaded start index.

Reset
REQ-031 rst low asynchronously clears: out_valid=0, dout=0, out_last=0, out_err=0, round_idx=0, direction=enc, all loaded bits=0, all key entries=0.
REQ-032 Reset mid-operation discards held output beat; no beat emitted after rst release until new accept.
REQ-033 in_ready SHALL be 1 during and after reset (out_valid=0).

Structure
REQ-034 Shared package: AES width constant (128), Nr+1 constants for 128/192/256, direction encoding.
REQ-035 One sub-module natural: add_rkey_seq (round counter with wrap/last/direction); bank and datapath stay in top.

Verification
REQ-036 FIPS-197 vector: key[0]=000102030405060708090a0b0c0d0e0f, din=00112233445566778899aabbccddeeff, sel_idx=0 -> dout=00102030405060708090a0b0c0d0e0f0, out_err=0, one cycle after accept.
REQ-037 Load 11 keys (NUM_KEYS=11), start dec=0, 11 beats auto_idx=1 -> keys 0..10 used in order, out_last only on 11th beat, round_idx back to 0.
REQ-038 Same with dec=1 -> keys 10..0, out_last on beat using key 0, round_idx returns to 10.
REQ-039 Hold out_ready=0 with beat pending, in_valid=1 -> in_ready=0, dout stable, counter not advanced; release -> beats in order, no loss or duplication.
REQ-040 Accept sel_idx=5 unloaded -> dout=din, out_err=1; sel_idx=15 (NUM_KEYS=15) -> same; write key 3 and accept index 3 same cycle -> old key used.
REQ-041 Assert rst low with out_valid=1 and round_idx=4 -> out_valid=0, round_idx=0, loaded bits cleared immediately, before next clk edge.
